// File: rtl/mem_byte_bridge.sv
// 16-bit CPU memory port bridged onto an 8-bit asynchronous SRAM.
// Each word access is split into low/high byte accesses with programmable wait states.
module mem_byte_bridge #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic [15:0] sram_addr,
  output logic        sram_cs_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] base_q, base_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        wr_q, wr_d;

  logic        resp_q, resp_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  swd_q, swd_d;
  logic        cs_n_q, cs_n_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        rdlast_q, rdlast_d;
  logic        hi_q, hi_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      swd_q    <= '0;
      cs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      rdlast_q <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      swd_q    <= swd_d;
      cs_n_q   <= cs_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      rdlast_q <= rdlast_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 4'd1 : '0;
    base_d  = base_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          base_d  = {mem_address[15:1], 1'b0};
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          wr_d    = mem_write;
          if (!mem_write)              state_d = LO;
          else if (mem_byte_enable[0]) state_d = LO;
          else if (mem_byte_enable[1]) state_d = HI;
          else                         state_d = RESP;
        end
      end
      LO:      if (cnt_q == '0) state_d = (!wr_q || be_q[1]) ? HI : RESP;
      HI:      if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q && (state_d == LO || state_d == HI)) cnt_d = WS;
  end

  // Strobes and capture controls lag the state by one cycle, so the read
  // capture uses a delayed "final cycle" flag to sample at the end of that cycle.
  always_comb begin
    resp_d   = (state_q == RESP);
    cs_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    addr_d   = addr_q;
    swd_d    = swd_q;
    rdlast_d = 1'b0;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    if (state_q == LO || state_q == HI) begin
      cs_n_d   = 1'b0;
      hi_d     = (state_q == HI);
      addr_d   = (state_q == HI) ? (base_q | 16'h0001) : base_q;
      swd_d    = (state_q == HI) ? wdata_q[15:8] : wdata_q[7:0];
      if (wr_q) we_n_d = (cnt_q == '0);
      else      oe_n_d = 1'b0;
      rdlast_d = !wr_q && (cnt_q == '0);
    end
    if (rdlast_q) rdata_d = hi_q ? {sram_rdata, rdata_q[7:0]} : {rdata_q[15:8], sram_rdata};
  end

  assign mem_resp   = resp_q;
  assign mem_rdata  = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = swd_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;

endmodule
